// File: rtl/spi_slave_param.sv
// SPI slave that runs entirely on CLK. SCK, SS and MOSI are synchronised and edge-detected here;
// the block has no logic clocked by SCK. All four CKP/CPH modes, any word width, and either bit order.
//   state    | meaning
//   ST_IDLE  | SS released; MISO held low; waiting for a synced SS falling edge
//   ST_SHIFT | SS asserted; sampling MOSI and advancing MISO on SCK edges
module spi_slave_param #(
   parameter int               DATA_W      = 16,
   parameter bit               MSB_FIRST   = 1'b1,
   parameter int               SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] TX_IDLE    = '0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              SCK,
   input  logic              SS,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              abort,
   output logic              tx_underrun
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
   logic sck_prev, ss_prev;
   logic sck_s, ss_s, mosi_s;
   logic ckp_l, cph_l;
   logic [CNT_W-1:0] bit_cnt;
   logic [DATA_W-1:0] tx_sr, rx_sr, rx_nxt, tx_buf, load_word;
   logic idle_word;
   logic miso_q;
   logic start, stop, sample, advance;
   logic sck_lead, sck_trail, ss_fall;
   logic word_done, reload, reload_buf, tx_accept, cph_eff;

   function automatic logic first_bit(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
   endfunction

   // SS chain resets low so a select held low through reset never looks like a fresh fall.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sck_sync  <= '0;
         ss_sync   <= '0;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         ss_prev   <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sck_prev  <= sck_s;
         ss_prev   <= ss_s;
      end
   end

   assign sck_s     = sck_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sck_lead  = (sck_s != sck_prev) && (sck_s != ckp_l);
   assign sck_trail = (sck_s != sck_prev) && (sck_s == ckp_l);
   assign ss_fall   = ss_prev && !ss_s;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // In CPH=0 the trailing edge right after a word's last sample is skipped: the reload already
   // put the next word's first bit on MISO.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      sample    = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ss_fall) begin
               state_nxt = ST_SHIFT;
               start     = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (ss_s) begin
               state_nxt = ST_IDLE;
               stop      = 1'b1;
            end else begin
               sample  = cph_l ? sck_trail : sck_lead;
               advance = cph_l ? sck_lead : (sck_trail && (bit_cnt != '0));
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_nxt = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};
   end

   assign word_done  = sample && (bit_cnt == LAST_BIT);
   assign reload     = start || word_done;
   assign reload_buf = reload && !tx_ready;
   assign load_word  = tx_ready ? TX_IDLE : tx_buf;
   assign tx_accept  = tx_load && (tx_ready || reload_buf);
   assign cph_eff    = start ? CPH : cph_l;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ckp_l       <= 1'b0;
         cph_l       <= 1'b0;
         bit_cnt     <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         abort       <= 1'b0;
         miso_q      <= 1'b0;
         tx_buf      <= '0;
         tx_ready    <= 1'b1;
         tx_underrun <= 1'b0;
         idle_word   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         abort    <= 1'b0;
         if (start) begin
            ckp_l   <= CKP;
            cph_l   <= CPH;
            bit_cnt <= '0;
         end
         if (stop) begin
            bit_cnt <= '0;
            abort   <= (bit_cnt != '0);
            miso_q  <= 1'b0;
         end
         if (sample) begin
            rx_sr   <= rx_nxt;
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            if (word_done) begin
               rx_data  <= rx_nxt;
               rx_valid <= 1'b1;
            end
         end
         if (reload) begin
            idle_word <= tx_ready;
            if (!cph_eff) begin
               miso_q <= first_bit(load_word);
               tx_sr  <= shift_out(load_word);
            end else begin
               tx_sr  <= load_word;
            end
         end else if (advance) begin
            miso_q <= first_bit(tx_sr);
            tx_sr  <= shift_out(tx_sr);
         end
         if (tx_accept) tx_buf <= tx_data;
         if (tx_accept)       tx_ready <= 1'b0;
         else if (reload_buf) tx_ready <= 1'b1;
         // Flagged when an idle-filled word really gets clocked, not when it is merely preloaded.
         if (sample && (bit_cnt == '0) && idle_word) tx_underrun <= 1'b1;
         else if (tx_accept)                         tx_underrun <= 1'b0;
      end
   end

   assign MISO = miso_q;
   assign busy = (state == ST_SHIFT);
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a 16-bit MSB-first and an 8-bit LSB-first slave share one SPI master.
// Expected RX words are queued per transfer and popped by a monitor on rx_valid.
module tb_spi_slave_param;
   localparam int H = 50;

   logic CLK = 1'b0, RESET_N = 1'b1, CKP = 1'b0, CPH = 1'b0, SCK = 1'b0, SS = 1'b1, MOSI = 1'b0;
   logic        miso16, tx_load16 = 1'b0, tx_ready16, rx_valid16, busy16, abort16, tx_underrun16;
   logic [15:0] tx_data16 = '0, rx_data16;
   logic        miso8, tx_load8 = 1'b0, tx_ready8, rx_valid8, busy8, abort8, tx_underrun8;
   logic [7:0]  tx_data8 = '0, rx_data8;

   int n_tests = 0, n_fail = 0;
   int rv16_cnt = 0, rv8_cnt = 0, ab16_cnt = 0, ab8_cnt = 0;
   logic [15:0] txq16[$], rxq16[$], last16 = '0;
   logic [7:0]  txq8[$],  rxq8[$],  last8 = '0;
   bit und16_m = 1'b0, und8_m = 1'b0;

   spi_slave_param #(.DATA_W(16), .MSB_FIRST(1'b1), .SYNC_STAGES(2), .TX_IDLE(16'h0000)) dut16 (
      .CLK(CLK), .RESET_N(RESET_N), .CKP(CKP), .CPH(CPH), .SCK(SCK), .SS(SS), .MOSI(MOSI),
      .MISO(miso16), .tx_data(tx_data16), .tx_load(tx_load16), .tx_ready(tx_ready16),
      .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16), .abort(abort16),
      .tx_underrun(tx_underrun16));

   spi_slave_param #(.DATA_W(8), .MSB_FIRST(1'b0), .SYNC_STAGES(3), .TX_IDLE(8'h00)) dut8 (
      .CLK(CLK), .RESET_N(RESET_N), .CKP(CKP), .CPH(CPH), .SCK(SCK), .SS(SS), .MOSI(MOSI),
      .MISO(miso8), .tx_data(tx_data8), .tx_load(tx_load8), .tx_ready(tx_ready8),
      .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8), .abort(abort8),
      .tx_underrun(tx_underrun8));

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (rx_valid16) begin
            rv16_cnt++;
            if (rxq16.size() == 0) check("rx16_unexpected", 64'(rx_data16), 64'hDEAD);
            else check("rx16_word", 64'(rx_data16), 64'(rxq16.pop_front()));
         end
         if (rx_valid8) begin
            rv8_cnt++;
            if (rxq8.size() == 0) check("rx8_unexpected", 64'(rx_data8), 64'hDEAD);
            else check("rx8_word", 64'(rx_data8), 64'(rxq8.pop_front()));
         end
         if (abort16) ab16_cnt++;
         if (abort8)  ab8_cnt++;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] msb_bits(input logic [15:0] w);
      logic [63:0] b = '0;
      for (int j = 0; j < 16; j++) b[j] = w[15-j];
      return b;
   endfunction

   task automatic load16(input logic [15:0] w);
      @(negedge CLK);
      check("tx_ready16_before", 64'(tx_ready16), 64'(txq16.size() == 0));
      tx_data16 = w;
      tx_load16 = 1'b1;
      @(negedge CLK);
      tx_load16 = 1'b0;
      if (txq16.size() == 0) begin
         txq16.push_back(w);
         und16_m = 1'b0;
      end
      check("tx_ready16_after", 64'(tx_ready16), 64'd0);
      check("underrun16_after_load", 64'(tx_underrun16), 64'(und16_m));
   endtask

   task automatic load8(input logic [7:0] w);
      @(negedge CLK);
      check("tx_ready8_before", 64'(tx_ready8), 64'(txq8.size() == 0));
      tx_data8 = w;
      tx_load8 = 1'b1;
      @(negedge CLK);
      tx_load8 = 1'b0;
      if (txq8.size() == 0) begin
         txq8.push_back(w);
         und8_m = 1'b0;
      end
      check("tx_ready8_after", 64'(tx_ready8), 64'd0);
   endtask

   // A word that starts with nothing buffered is filled with the idle pattern (zero here).
   task automatic pop16(input bit used, output logic [15:0] w);
      if (txq16.size() > 0) w = txq16.pop_front();
      else begin
         w = 16'h0000;
         if (used) und16_m = 1'b1;
      end
   endtask

   task automatic pop8(input bit used, output logic [7:0] w);
      if (txq8.size() > 0) w = txq8.pop_front();
      else begin
         w = 8'h00;
         if (used) und8_m = 1'b1;
      end
   endtask

   task automatic set_mode(input int m);
      @(negedge CLK);
      CKP = m[1];
      CPH = m[0];
      SCK = CKP;
      #(4*H);
   endtask

   // Master: n SCK periods, bits[i] is the i-th MOSI bit in time; MISO is captured at the master's sample edge.
   task automatic xfer(input int n, input logic [63:0] bits, input bit chk);
      logic [63:0] act16, exp16, act8, exp8;
      logic [15:0] cur16, w16;
      logic [7:0]  cur8, w8;
      int rv16_0, rv8_0, ab16_0, ab8_0;
      act16 = '0; exp16 = '0; act8 = '0; exp8 = '0; cur16 = '0; cur8 = '0;
      if (chk) begin
         for (int k = 0; k < n / 16; k++) begin
            for (int j = 0; j < 16; j++) w16[15-j] = bits[k*16+j];
            rxq16.push_back(w16);
            last16 = w16;
         end
         for (int k = 0; k < n / 8; k++) begin
            for (int j = 0; j < 8; j++) w8[j] = bits[k*8+j];
            rxq8.push_back(w8);
            last8 = w8;
         end
      end
      rv16_0 = rv16_cnt; rv8_0 = rv8_cnt; ab16_0 = ab16_cnt; ab8_0 = ab8_cnt;
      MOSI = bits[0];
      SS = 1'b0;
      #(2*H);
      for (int i = 0; i < n; i++) begin
         if (i % 16 == 0) pop16(1'b1, cur16);
         if (i % 8 == 0)  pop8(1'b1, cur8);
         exp16[i] = cur16[15 - (i % 16)];
         exp8[i]  = cur8[i % 8];
         if (chk && i == 1) check("busy16_active", 64'(busy16), 64'd1);
         if (!CPH) begin
            act16[i] = miso16; act8[i] = miso8;
            SCK = ~CKP; #H;
            SCK = CKP;
            MOSI = (i + 1 < n) ? bits[i+1] : 1'b0;
            #H;
         end else begin
            SCK = ~CKP; MOSI = bits[i]; #H;
            act16[i] = miso16; act8[i] = miso8;
            SCK = CKP; #H;
         end
      end
      if (n > 0 && n % 16 == 0) pop16(1'b0, cur16);
      if (n > 0 && n % 8 == 0)  pop8(1'b0, cur8);
      #H;
      SS = 1'b1;
      #(4*H);
      if (chk) begin
         check("miso16_stream", act16, exp16);
         check("miso8_stream", act8, exp8);
         check("rx_valid16_count", 64'(rv16_cnt - rv16_0), 64'(n / 16));
         check("rx_valid8_count", 64'(rv8_cnt - rv8_0), 64'(n / 8));
         check("abort16_count", 64'(ab16_cnt - ab16_0), 64'(n % 16 != 0));
         check("abort8_count", 64'(ab8_cnt - ab8_0), 64'(n % 8 != 0));
         check("rx_data16_hold", 64'(rx_data16), 64'(last16));
         check("rx_data8_hold", 64'(rx_data8), 64'(last8));
         check("underrun16", 64'(tx_underrun16), 64'(und16_m));
         check("underrun8", 64'(tx_underrun8), 64'(und8_m));
         check("busy16_idle", 64'(busy16), 64'd0);
         check("miso16_idle", 64'(miso16), 64'd0);
      end
   endtask

   task automatic check_reset_values();
      check("rst_miso16", 64'(miso16), 64'd0);
      check("rst_tx_ready16", 64'(tx_ready16), 64'd1);
      check("rst_rx_data16", 64'(rx_data16), 64'd0);
      check("rst_rx_valid16", 64'(rx_valid16), 64'd0);
      check("rst_busy16", 64'(busy16), 64'd0);
      check("rst_abort16", 64'(abort16), 64'd0);
      check("rst_underrun16", 64'(tx_underrun16), 64'd0);
      check("rst_tx_ready8", 64'(tx_ready8), 64'd1);
      check("rst_rx_data8", 64'(rx_data8), 64'd0);
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_underrun8", 64'(tx_underrun8), 64'd0);
   endtask

   initial begin
      int n, rv_before;
      logic [63:0] rb;
      #2 RESET_N = 1'b0;
      repeat (5) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLK);
      check_reset_values();

      // Same words through all four modes.
      for (int m = 0; m < 4; m++) begin
         set_mode(m);
         load16(16'h0402);
         xfer(16, msb_bits(16'hA5C3), 1'b1);
      end

      // Back-to-back words with the second loaded while the first shifts.
      set_mode(0);
      load16(16'h1111);
      rb = msb_bits(16'hA5C3) | (msb_bits(16'(($urandom))) << 16);
      fork
         xfer(32, rb, 1'b1);
         begin #(2*H + 6*H + 20); load16(16'h2222); end
      join

      // Nothing loaded: idle pattern shifted, underrun raised, then cleared by a load.
      set_mode(int'($urandom_range(0, 3)));
      xfer(16, 64'($urandom), 1'b1);
      load16(16'($urandom));

      // SS released after 5 clocks.
      xfer(5, 64'($urandom), 1'b1);

      // LSB-first 8-bit slave: first MISO bit is bit 0 of the loaded word.
      set_mode(0);
      load8(8'h01);
      xfer(8, 64'h01, 1'b1);

      for (int t = 0; t < 6; t++) begin
         set_mode(int'($urandom_range(0, 3)));
         n = 8 * int'($urandom_range(1, 5));
         if ($urandom_range(0, 1) == 1) load16(16'($urandom));
         if ($urandom_range(0, 1) == 1) load8(8'($urandom));
         rb = {$urandom, $urandom};
         fork
            xfer(n, rb, 1'b1);
            begin
               #(2*H + 6*H + 20);
               if (n > 8 && $urandom_range(0, 1) == 1) load16(16'($urandom));
            end
         join
      end

      // Reset pulse mid-word with SS held low: slaves stay idle until a fresh SS fall.
      set_mode(0);
      load16(16'($urandom));
      rv_before = rv16_cnt + rv8_cnt;
      fork
         xfer(16, 64'($urandom), 1'b0);
         begin
            #(2*H + 10*H + 20);
            RESET_N = 1'b0;
            #30;
            RESET_N = 1'b1;
            #(4*H);
            check("busy16_after_reset", 64'(busy16), 64'd0);
            check("busy8_after_reset", 64'(busy8), 64'd0);
         end
      join
      txq16.delete(); txq8.delete();
      und16_m = 1'b0; und8_m = 1'b0; last16 = '0; last8 = '0;
      check("rx_valid_after_reset", 64'(rv16_cnt + rv8_cnt), 64'(rv_before));
      check_reset_values();

      load16(16'h5A3C);
      xfer(16, msb_bits(16'h3C96), 1'b1);

      repeat (10) @(negedge CLK);
      check("rxq16_drained", 64'(rxq16.size()), 64'd0);
      check("rxq8_drained", 64'(rxq8.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
